// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int uart_tick_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Word delivery bundle: holding-register outputs and consumer ready.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output valid,
    input  ready,
    output parity_err,
    output frame_err,
    output overrun
  );

  modport slave (
    input  data_out,
    input  valid,
    output ready,
    input  parity_err,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_os_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DIV =
    uart_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == C_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling and a
// one-entry valid/ready holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int OVERSAMPLE  = 16,
  parameter int BAUD_RATE   = 9600,
  parameter int CLK_FREQ    = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_rx_os_if.master  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY_MODE != PARITY_NONE);
  localparam logic ODD_PAR = (PARITY_MODE == PARITY_ODD);

  logic r_sync1, r_rxs;
  logic w_tick;

  uart_rx_state_t r_state, w_next;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;

  logic [DATA_BITS-1:0] r_data;
  logic r_valid, r_pe, r_fe, r_ovr;

  logic w_half, w_full, w_commit, w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  uart_os_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_half   = w_tick && (r_tcnt == T_HALF);
  assign w_full   = w_tick && (r_tcnt == T_FULL);
  assign w_commit = (r_state == S_STOP) && w_full
                    && (r_bcnt == S_LAST);
  assign w_accept = r_valid && bus.ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_tick && !r_rxs) w_next = S_START;
      S_START:
        if (w_half) w_next = r_rxs ? S_IDLE : S_DATA;
      S_DATA:
        if (w_full && (r_bcnt == B_LAST))
          w_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY:
        if (w_full) w_next = S_STOP;
      S_STOP:
        if (w_commit) w_next = r_rxs ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE:
        if (r_rxs) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Counters restart on every state change so each phase times itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if ((r_state != w_next) || w_full) r_tcnt <= '0;
      else if (w_tick)                   r_tcnt <= r_tcnt + 1'b1;

      if (r_state != w_next) r_bcnt <= '0;
      else if (w_full)       r_bcnt <= r_bcnt + 1'b1;

      if ((r_state == S_DATA) && w_full)
        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};

      if (r_state == S_START)
        r_perr <= 1'b0;
      else if ((r_state == S_PARITY) && w_full)
        r_perr <= (^{r_shift, r_rxs}) ^ ODD_PAR;

      if (r_state == S_START)
        r_ferr <= 1'b0;
      else if ((r_state == S_STOP) && w_full && !r_rxs)
        r_ferr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_commit) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_pe    <= r_perr;
          r_fe    <= r_ferr | ~r_rxs;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_pe;
  assign bus.frame_err  = r_fe;
  assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: 8N1, 8E1 and 8N2 instances.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int BITC = 160;

  typedef struct {
    int d;
    int pe;
    int fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nacc [3] = '{0, 0, 0};
  int novr [3] = '{0, 0, 0};
  int acc_cyc0 = 0;
  exp_t q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_os_if #(.DATA_BITS(8)) if0 ();
  uart_rx_os_if #(.DATA_BITS(8)) if1 ();
  uart_rx_os_if #(.DATA_BITS(8)) if2 ();

  uart_rx_os #(
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0),
    .OVERSAMPLE(16), .BAUD_RATE(10000), .CLK_FREQ(1600000)
  ) u0 (.clk(clk), .reset(reset), .rx(rx0), .bus(if0.master));

  uart_rx_os #(
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1),
    .OVERSAMPLE(16), .BAUD_RATE(10000), .CLK_FREQ(1600000)
  ) u1 (.clk(clk), .reset(reset), .rx(rx1), .bus(if1.master));

  uart_rx_os #(
    .DATA_BITS(8), .STOP_BITS(2), .PARITY_MODE(0),
    .OVERSAMPLE(16), .BAUD_RATE(10000), .CLK_FREQ(1600000)
  ) u2 (.clk(clk), .reset(reset), .rx(rx2), .bus(if2.master));

  task automatic chk(input string nm, input int got,
                     input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int idx, input int d,
                     input int pe, input int fe);
    exp_t e;
    nacc[idx]++;
    if (q[idx].size() == 0) begin
      total++;
      bad++;
      $display("FAIL u%0d unexpected word got=%0h exp=none",
               idx, d);
    end else begin
      e = q[idx].pop_front();
      chk($sformatf("u%0d data", idx), d, e.d);
      chk($sformatf("u%0d parity_err", idx), pe, e.pe);
      chk($sformatf("u%0d frame_err", idx), fe, e.fe);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (if0.valid && if0.ready) begin
      acc_cyc0 = cyc;
      mon(0, int'(if0.data_out), int'(if0.parity_err),
          int'(if0.frame_err));
    end
    if (if1.valid && if1.ready)
      mon(1, int'(if1.data_out), int'(if1.parity_err),
          int'(if1.frame_err));
    if (if2.valid && if2.ready)
      mon(2, int'(if2.data_out), int'(if2.parity_err),
          int'(if2.frame_err));
    if (if0.overrun) novr[0]++;
    if (if1.overrun) novr[1]++;
    if (if2.overrun) novr[2]++;
  end

  task automatic push(input int idx, input int d,
                      input int pe, input int fe);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    q[idx].push_back(e);
  endtask

  task automatic bitx(input int idx, input logic v);
    case (idx)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send(input int idx, input logic [7:0] d,
                      input bit hp, input bit p, input bit s1,
                      input bit hs2, input bit s2);
    bitx(idx, 1'b0);
    for (int i = 0; i < 8; i++) bitx(idx, d[i]);
    if (hp) bitx(idx, p);
    bitx(idx, s1);
    if (hs2) bitx(idx, s2);
  endtask

  int t0, n0, ov0;
  bit seen;

  initial begin
    if0.ready = 1'b1;
    if1.ready = 1'b1;
    if2.ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst valid", int'(if0.valid), 0);
    chk("rst data", int'(if0.data_out), 0);
    chk("rst state", int'(u0.r_state), int'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // 8N1 0xA5 with latency window
    push(0, 'hA5, 0, 0);
    t0 = cyc;
    send(0, 8'hA5, 0, 0, 1, 0, 0);
    chk("A5 accepted", nacc[0], 1);
    total++;
    if ((acc_cyc0 - t0) < 1520 || (acc_cyc0 - t0) > 1536) begin
      bad++;
      $display("FAIL A5 latency got=%0d exp=1520..1536",
               acc_cyc0 - t0);
    end
    chk("A5 valid dropped", int'(if0.valid), 0);
    repeat (100) @(negedge clk);

    // short glitch must not start a frame
    n0 = nacc[0];
    rx0 = 1'b0;
    repeat (40) @(negedge clk);
    rx0 = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch idle", int'(u0.r_state), int'(S_IDLE));
    chk("glitch no word", nacc[0], n0);
    push(0, 'h3C, 0, 0);
    send(0, 8'h3C, 0, 0, 1, 0, 0);
    repeat (100) @(negedge clk);

    // overrun with ready low
    if0.ready = 1'b0;
    ov0 = novr[0];
    push(0, 'h11, 0, 0);
    send(0, 8'h11, 0, 0, 1, 0, 0);
    send(0, 8'h22, 0, 0, 1, 0, 0);
    #1;
    chk("ovr pulses", novr[0] - ov0, 1);
    chk("ovr held data", int'(if0.data_out), 'h11);
    chk("ovr held valid", int'(if0.valid), 1);
    if0.ready = 1'b1;
    repeat (5) @(negedge clk);
    if0.ready = 1'b0;

    // ready rises in the same cycle as the second commit
    push(0, 'h33, 0, 0);
    send(0, 8'h33, 0, 0, 1, 0, 0);
    push(0, 'h44, 0, 0);
    ov0 = novr[0];
    seen = 1'b0;
    fork
      send(0, 8'h44, 0, 0, 1, 0, 0);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (u0.w_commit) begin
            if0.ready = 1'b1;
            seen = 1'b1;
            break;
          end
        end
      end
    join
    chk("commit seen", int'(seen), 1);
    if0.ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("same-cycle no ovr", novr[0] - ov0, 0);
    repeat (100) @(negedge clk);

    // reset in the middle of DATA for 0xFF
    bitx(0, 1'b0);
    for (int i = 0; i < 3; i++) bitx(0, 1'b1);
    ov0 = novr[0];
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("mid rst valid", int'(if0.valid), 0);
    chk("mid rst data", int'(if0.data_out), 0);
    chk("mid rst pe", int'(if0.parity_err), 0);
    chk("mid rst fe", int'(if0.frame_err), 0);
    chk("mid rst ovr", int'(if0.overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (1800) @(negedge clk);
    chk("mid rst no ovr", novr[0] - ov0, 0);
    push(0, 'h5A, 0, 0);
    send(0, 8'h5A, 0, 0, 1, 0, 0);
    repeat (100) @(negedge clk);

    // even parity: 0x07 has three ones
    push(1, 'h07, 1, 0);
    send(1, 8'h07, 1, 0, 1, 0, 0);
    repeat (50) @(negedge clk);
    push(1, 'h07, 0, 0);
    send(1, 8'h07, 1, 1, 1, 0, 0);
    repeat (100) @(negedge clk);

    // two stop bits, second low, then a held break
    n0 = nacc[2];
    push(2, 'h81, 0, 1);
    send(2, 8'h81, 0, 0, 1, 1, 0);
    repeat (2000) @(negedge clk);
    chk("break wait", int'(u2.r_state), int'(S_WAIT_IDLE));
    rx2 = 1'b1;
    repeat (300) @(negedge clk);
    chk("break one word", nacc[2] - n0, 1);
    push(2, 'h66, 0, 0);
    send(2, 8'h66, 0, 0, 1, 1, 1);
    repeat (100) @(negedge clk);

    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d queue left", i), q[i].size(), 0);
    chk("u1 ovr", novr[1], 0);
    chk("u2 ovr", novr[2], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
